// File: rtl/ecfg_pkg.sv
// ecfg_pkg: register map, field positions, AXI response codes and FSM states for ecfg_regs
package ecfg_pkg;
    localparam logic [2:0] REG_SYSRESET = 3'd0;
    localparam logic [2:0] REG_ELINKCFG = 3'd1;
    localparam logic [2:0] REG_TXFORCE  = 3'd2;
    localparam logic [2:0] REG_RXCFG    = 3'd3;
    localparam logic [2:0] REG_FILT_LO  = 3'd4;
    localparam logic [2:0] REG_FILT_HI  = 3'd5;
    localparam logic [2:0] REG_COREID   = 3'd6;
    localparam logic [2:0] REG_VERSION  = 3'd7;
    localparam int F_ELINK_EN    = 0;
    localparam int F_LCLKDIV     = 1;
    localparam int F_CTRLMODE    = 4;
    localparam int F_LOOPBACK    = 8;
    localparam int F_FORCE_MODE  = 9;
    localparam int F_FILTER_MODE = 16;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [31:0] VERSION = 32'h0001_0000;
    typedef enum logic [1:0] {ST_IDLE, ST_WRESP, ST_RRESP} state_t;
    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i+:8] = strb[i] ? wd[8*i+:8] : old[8*i+:8];
        return r;
    endfunction
endpackage

// File: rtl/ecfg_regs.sv
// ecfg_regs: AXI4-Lite register file driving the static elink ecfg_* configuration pins.
// Ports: s_axi_* AXI4-Lite slave (clock s_axi_aclk, sync active-low reset s_axi_aresetn);
//   ecfg_sw_reset RST_CYCLES-long pulse on SYSRESET write of bit0=1; remaining ecfg_* are
//   registered config fields. Define ECFG_RX_FILTER_EN to implement the RX filter registers;
//   otherwise they read 0, ignore writes and the filter outputs are tied 0 (pass all).
module ecfg_regs import ecfg_pkg::*; #(
    parameter int SAW = 32,
    parameter int SDW = 32,
    parameter int EIDW = 12,
    parameter int VMW = 4,
    parameter int MAW = 32,
    parameter int RST_CYCLES = 16,
    parameter logic [EIDW-1:0] COREID_RST = 12'h810
) (
    input  logic            s_axi_aclk,
    input  logic            s_axi_aresetn,
    input  logic [SAW-1:0]  s_axi_awaddr,
    input  logic            s_axi_awvalid,
    output logic            s_axi_awready,
    input  logic [SDW-1:0]  s_axi_wdata,
    input  logic [3:0]      s_axi_wstrb,
    input  logic            s_axi_wvalid,
    output logic            s_axi_wready,
    output logic [1:0]      s_axi_bresp,
    output logic            s_axi_bvalid,
    input  logic            s_axi_bready,
    input  logic [SAW-1:0]  s_axi_araddr,
    input  logic            s_axi_arvalid,
    output logic            s_axi_arready,
    output logic [SDW-1:0]  s_axi_rdata,
    output logic [1:0]      s_axi_rresp,
    output logic            s_axi_rvalid,
    input  logic            s_axi_rready,
    output logic            ecfg_sw_reset,
    output logic [EIDW-1:0] ecfg_coreid,
    output logic            ecfg_elink_en,
    output logic [1:0]      ecfg_lclkdiv,
    output logic [3:0]      ecfg_ctrlmode,
    output logic            ecfg_tx_loopback_mode,
    output logic            ecfg_tx_force_mode,
    output logic [8:0]      ecfg_tx_force_data,
    output logic [VMW-1:0]  ecfg_rx_remap_addr,
    output logic [1:0]      ecfg_rx_filter_mode,
    output logic [MAW-1:0]  ecfg_rx_filter_lo_addr,
    output logic [MAW-1:0]  ecfg_rx_filter_hi_addr
);
    localparam int CW = $clog2(RST_CYCLES + 1);

    state_t           r_state, w_state_nxt;
    logic             w_wr_acc, w_rd_acc, w_werr, w_rerr, w_wen, w_sw_start;
    logic [2:0]       w_wsel, w_rsel;
    logic [SDW-1:0]   w_regs [8];
    logic [SDW-1:0]   w_merged;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_sw_reset;
    logic [1:0]       r_bresp, r_rresp;
    logic [SDW-1:0]   r_rdata;
    logic             r_elink_en, r_loopback, r_force_mode;
    logic [1:0]       r_lclkdiv;
    logic [3:0]       r_ctrlmode;
    logic [8:0]       r_force_data;
    logic [VMW-1:0]   r_remap;
    logic [EIDW-1:0]  r_coreid;
    logic [1:0]       w_filter_mode;
    logic [MAW-1:0]   w_filt_lo, w_filt_hi;
    logic             w_unused;

    // Reset is folded into the accepts so no ready is raised while held in reset.
    assign w_wr_acc = s_axi_aresetn && r_state == ST_IDLE && s_axi_awvalid && s_axi_wvalid;
    assign w_rd_acc = s_axi_aresetn && r_state == ST_IDLE && s_axi_arvalid && !(s_axi_awvalid && s_axi_wvalid);
    assign w_wsel = s_axi_awaddr[4:2];
    assign w_rsel = s_axi_araddr[4:2];
    assign w_werr = |s_axi_awaddr[SAW-1:5];
    assign w_rerr = |s_axi_araddr[SAW-1:5];
    assign w_wen = w_wr_acc && !w_werr;
    assign w_merged = byte_merge(w_regs[w_wsel], s_axi_wdata, s_axi_wstrb);
    assign w_sw_start = w_wen && w_wsel == REG_SYSRESET && s_axi_wstrb[0] && s_axi_wdata[0];
    assign w_cnt_nxt = w_sw_start ? CW'(RST_CYCLES) : (r_cnt != '0 ? r_cnt - CW'(1) : r_cnt);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = w_wr_acc ? ST_WRESP : (w_rd_acc ? ST_RRESP : ST_IDLE);
            ST_WRESP: w_state_nxt = s_axi_bready ? ST_IDLE : ST_WRESP;
            ST_RRESP: w_state_nxt = s_axi_rready ? ST_IDLE : ST_RRESP;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Read view of every register; also the base that byte-lane writes merge into.
    always_comb begin
        w_regs = '{default: '0};
        w_regs[REG_SYSRESET][0] = r_sw_reset;
        w_regs[REG_ELINKCFG][F_ELINK_EN] = r_elink_en;
        w_regs[REG_ELINKCFG][F_LCLKDIV+:2] = r_lclkdiv;
        w_regs[REG_ELINKCFG][F_CTRLMODE+:4] = r_ctrlmode;
        w_regs[REG_ELINKCFG][F_LOOPBACK] = r_loopback;
        w_regs[REG_ELINKCFG][F_FORCE_MODE] = r_force_mode;
        w_regs[REG_TXFORCE][8:0] = r_force_data;
        w_regs[REG_RXCFG][VMW-1:0] = r_remap;
        w_regs[REG_RXCFG][F_FILTER_MODE+:2] = w_filter_mode;
        w_regs[REG_FILT_LO][MAW-1:0] = w_filt_lo;
        w_regs[REG_FILT_HI][MAW-1:0] = w_filt_hi;
        w_regs[REG_COREID][EIDW-1:0] = r_coreid;
        w_regs[REG_VERSION] = VERSION;
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_state <= ST_IDLE;
            r_cnt <= '0;
            r_sw_reset <= 1'b0;
            r_bresp <= RESP_OKAY;
            r_rresp <= RESP_OKAY;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt <= w_cnt_nxt;
            r_sw_reset <= w_cnt_nxt != '0;
            if (w_wr_acc) r_bresp <= w_werr ? RESP_SLVERR : RESP_OKAY;
            if (w_rd_acc) begin
                r_rresp <= w_rerr ? RESP_SLVERR : RESP_OKAY;
                r_rdata <= w_rerr ? '0 : w_regs[w_rsel];
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_elink_en <= 1'b0;
            r_lclkdiv <= '0;
            r_ctrlmode <= '0;
            r_loopback <= 1'b0;
            r_force_mode <= 1'b0;
            r_force_data <= '0;
            r_remap <= '0;
            r_coreid <= COREID_RST;
        end else if (w_wen) begin
            if (w_wsel == REG_ELINKCFG) begin
                r_elink_en <= w_merged[F_ELINK_EN];
                r_lclkdiv <= w_merged[F_LCLKDIV+:2];
                r_ctrlmode <= w_merged[F_CTRLMODE+:4];
                r_loopback <= w_merged[F_LOOPBACK];
                r_force_mode <= w_merged[F_FORCE_MODE];
            end
            if (w_wsel == REG_TXFORCE) r_force_data <= w_merged[8:0];
            if (w_wsel == REG_RXCFG) r_remap <= w_merged[VMW-1:0];
            if (w_wsel == REG_COREID) r_coreid <= w_merged[EIDW-1:0];
        end
    end

`ifdef ECFG_RX_FILTER_EN
    logic [1:0]     r_filter_mode;
    logic [MAW-1:0] r_filt_lo, r_filt_hi;
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_filter_mode <= '0;
            r_filt_lo <= '0;
            r_filt_hi <= '0;
        end else if (w_wen) begin
            if (w_wsel == REG_RXCFG) r_filter_mode <= w_merged[F_FILTER_MODE+:2];
            if (w_wsel == REG_FILT_LO) r_filt_lo <= w_merged[MAW-1:0];
            if (w_wsel == REG_FILT_HI) r_filt_hi <= w_merged[MAW-1:0];
        end
    end
    assign w_filter_mode = r_filter_mode;
    assign w_filt_lo = r_filt_lo;
    assign w_filt_hi = r_filt_hi;
`else
    assign w_filter_mode = '0;
    assign w_filt_lo = '0;
    assign w_filt_hi = '0;
`endif

    assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], w_merged};

    assign s_axi_awready = w_wr_acc;
    assign s_axi_wready = w_wr_acc;
    assign s_axi_arready = w_rd_acc;
    assign s_axi_bvalid = r_state == ST_WRESP;
    assign s_axi_bresp = r_bresp;
    assign s_axi_rvalid = r_state == ST_RRESP;
    assign s_axi_rresp = r_rresp;
    assign s_axi_rdata = r_rdata;
    assign ecfg_sw_reset = r_sw_reset;
    assign ecfg_coreid = r_coreid;
    assign ecfg_elink_en = r_elink_en;
    assign ecfg_lclkdiv = r_lclkdiv;
    assign ecfg_ctrlmode = r_ctrlmode;
    assign ecfg_tx_loopback_mode = r_loopback;
    assign ecfg_tx_force_mode = r_force_mode;
    assign ecfg_tx_force_data = r_force_data;
    assign ecfg_rx_remap_addr = r_remap;
    assign ecfg_rx_filter_mode = w_filter_mode;
    assign ecfg_rx_filter_lo_addr = w_filt_lo;
    assign ecfg_rx_filter_hi_addr = w_filt_hi;
endmodule

// File: tb/tb_ecfg_regs.sv
// tb_ecfg_regs: directed, table-driven self-checking bench for ecfg_regs
module tb_ecfg_regs;
`ifdef ECFG_RX_FILTER_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        sw_reset, elink_en, loopback, force_mode;
    logic [11:0] coreid;
    logic [1:0]  lclkdiv, filter_mode;
    logic [3:0]  ctrlmode, remap;
    logic [8:0]  force_data;
    logic [31:0] filt_lo, filt_hi;
    int          n_pass = 0, n_total = 0;
    int          cyc = 0, acc_cyc = 0, hi_cnt = 0;

    always #5 clk = ~clk;

    ecfg_regs dut (
        .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .ecfg_sw_reset(sw_reset), .ecfg_coreid(coreid), .ecfg_elink_en(elink_en),
        .ecfg_lclkdiv(lclkdiv), .ecfg_ctrlmode(ctrlmode), .ecfg_tx_loopback_mode(loopback),
        .ecfg_tx_force_mode(force_mode), .ecfg_tx_force_data(force_data),
        .ecfg_rx_remap_addr(remap), .ecfg_rx_filter_mode(filter_mode),
        .ecfg_rx_filter_lo_addr(filt_lo), .ecfg_rx_filter_hi_addr(filt_hi)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (awvalid && awready) acc_cyc <= cyc;
    end

    always @(negedge clk) if (sw_reset) hi_cnt <= hi_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else n_pass++;
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
        int n;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        #1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); #1; n++; end
        if (n == 20) timeout("awready");
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        if (n == 20) timeout("bvalid");
        resp = bresp;
        @(posedge clk); #1;
        bready = 0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [1:0] resp, output logic [31:0] d);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1; rready = 1;
        #1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); #1; n++; end
        if (n == 20) timeout("arready");
        @(posedge clk); #1;
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        if (n == 20) timeout("rvalid");
        resp = rresp; d = rdata;
        @(posedge clk); #1;
        rready = 0;
    endtask

    typedef struct {
        logic [31:0] waddr, wdata;
        logic [3:0]  wstrb;
        logic [1:0]  bresp;
        logic [31:0] raddr;
        logic [1:0]  rresp;
        logic [31:0] rdata;
    } vec_t;

    initial begin
        vec_t        tbl [12];
        logic [1:0]  r;
        logic [31:0] d;
        int          t0;
        tbl[0]  = '{32'h04, 32'h0000_02F5, 4'hF, 2'b00, 32'h04, 2'b00, 32'h0000_02F5};
        tbl[1]  = '{32'h18, 32'h0000_0ABC, 4'h1, 2'b00, 32'h18, 2'b00, 32'h0000_08BC};
        tbl[2]  = '{32'h08, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h08, 2'b00, 32'h0000_01FF};
        tbl[3]  = '{32'h0C, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0C, 2'b00, FE ? 32'h0003_000F : 32'h0000_000F};
        tbl[4]  = '{32'h10, 32'h0000_FFFF, 4'hF, 2'b00, 32'h10, 2'b00, FE ? 32'h0000_FFFF : 32'h0};
        tbl[5]  = '{32'h14, 32'hFFFF_FFFF, 4'hC, 2'b00, 32'h14, 2'b00, FE ? 32'hFFFF_0000 : 32'h0};
        tbl[6]  = '{32'h1C, 32'h0000_1234, 4'hF, 2'b00, 32'h1C, 2'b00, 32'h0001_0000};
        tbl[7]  = '{32'h40, 32'h0000_0001, 4'hF, 2'b10, 32'h40, 2'b10, 32'h0};
        tbl[8]  = '{32'h04, 32'h0000_0000, 4'h2, 2'b00, 32'h04, 2'b00, 32'h0000_00F5};
        tbl[9]  = '{32'h24, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h04, 2'b00, 32'h0000_00F5};
        tbl[10] = '{32'h18, 32'h0000_0000, 4'h2, 2'b00, 32'h18, 2'b00, 32'h0000_00BC};
        tbl[11] = '{32'h00, 32'h0000_0000, 4'hF, 2'b00, 32'h00, 2'b00, 32'h0};

        repeat (3) @(posedge clk);
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(negedge clk);
        chk("rst_awready", {31'b0, awready}, 32'h0);
        chk("rst_arready", {31'b0, arready}, 32'h0);
        awvalid = 0; wvalid = 0; arvalid = 0;
        @(negedge clk);
        aresetn = 1;
        @(negedge clk);
        chk("rst_coreid", {20'b0, coreid}, 32'h810);
        chk("rst_valids", {30'b0, bvalid, rvalid}, 32'h0);
        chk("rst_cfg", {sw_reset, elink_en, lclkdiv, ctrlmode, loopback, force_mode, force_data, remap, filter_mode}, 32'h0);
        chk("rst_filt", filt_lo | filt_hi, 32'h0);

        axi_write(32'h04, 32'h0000_02F5, 4'hF, r);
        chk("elink_bresp", {30'b0, r}, 32'h0);
        chk("elink_fields", {elink_en, lclkdiv, ctrlmode, force_mode, loopback}, {1'b1, 2'd2, 4'hF, 1'b1, 1'b0});

        for (int i = 0; i < 12; i++) begin
            axi_write(tbl[i].waddr, tbl[i].wdata, tbl[i].wstrb, r);
            chk($sformatf("vec%0d_bresp", i), {30'b0, r}, {30'b0, tbl[i].bresp});
            axi_read(tbl[i].raddr, r, d);
            chk($sformatf("vec%0d_rresp", i), {30'b0, r}, {30'b0, tbl[i].rresp});
            chk($sformatf("vec%0d_rdata", i), d, tbl[i].rdata);
        end

        chk("out_coreid", {20'b0, coreid}, 32'h0BC);
        chk("out_elink", {elink_en, lclkdiv, ctrlmode, force_mode, loopback}, {1'b1, 2'd2, 4'hF, 1'b0, 1'b0});
        chk("out_force_data", {23'b0, force_data}, 32'h1FF);
        chk("out_remap", {28'b0, remap}, 32'hF);
        chk("out_filter_mode", {30'b0, filter_mode}, FE ? 32'h3 : 32'h0);
        chk("out_filt_lo", filt_lo, FE ? 32'h0000_FFFF : 32'h0);
        chk("out_filt_hi", filt_hi, FE ? 32'hFFFF_0000 : 32'h0);
        chk("sw_reset_zero_write", hi_cnt, 0);

        // Simultaneous write and read: write first, bready stalled for 5 cycles.
        @(negedge clk);
        awaddr = 32'h08; wdata = 32'h55; wstrb = 4'hF; araddr = 32'h08;
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 0; rready = 0;
        #1;
        chk("prio_awready", {31'b0, awready}, 32'h1);
        chk("prio_arready", {31'b0, arready}, 32'h0);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_bvalid_arready", i), {30'b0, bvalid, arready}, 32'h2);
        end
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        @(negedge clk);
        chk("prio_ar_after_b", {30'b0, bvalid, arready}, 32'h1);
        @(posedge clk); #1;
        arvalid = 0;
        repeat (2) @(negedge clk);
        chk("prio_rvalid_rdata", {rvalid, rdata[30:0]}, {1'b1, 31'h55});
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
        @(negedge clk);
        chk("prio_rvalid_drop", {31'b0, rvalid}, 32'h0);

        // Single sw reset pulse, with a status read while active.
        hi_cnt = 0;
        axi_write(32'h00, 32'h1, 4'hF, r);
        axi_read(32'h00, r, d);
        chk("sysreset_active", d, 32'h1);
        repeat (30) @(negedge clk);
        chk("sw_reset_len16", hi_cnt, 16);
        axi_read(32'h00, r, d);
        chk("sysreset_idle", d, 32'h0);

        // Rewrite 10 cycles into the pulse reloads the counter.
        hi_cnt = 0;
        axi_write(32'h00, 32'h1, 4'hF, r);
        t0 = acc_cyc;
        while (cyc < t0 + 9) @(negedge clk);
        axi_write(32'h00, 32'h1, 4'hF, r);
        chk("rewrite_gap", acc_cyc - t0, 10);
        repeat (40) @(negedge clk);
        chk("sw_reset_len26", hi_cnt, 26);
        chk("cfg_kept", {20'b0, coreid}, 32'h0BC);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
